// File: rtl/adc_pkg.sv
// Shared types and defaults for the ADC arbiter: FSM state encoding, client count,
// timeout and data width.
package adc_pkg;

    localparam int unsigned N_CLIENTS_DEFAULT      = 4;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;
    localparam int unsigned DATA_W                 = 8;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StDone,
        StRelease,
        StErr
    } state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: the client just after 'last' has top priority,
// and the winner is returned one-hot (all-zero when nobody requests).
module rr_picker
    import adc_pkg::*;
#(
    parameter int unsigned N    = N_CLIENTS_DEFAULT,
    parameter int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] last,
    output logic [N-1:0]    winner
);

    logic [IdxW-1:0] idx;

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        winner = '0;
        idx    = '0;
        for (int unsigned off = N; off >= 1; off--) begin
            idx = IdxW'((32'(last) + off) % N);
            if (req[idx]) begin
                winner      = '0;
                winner[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_arbiter.sv
// Round-robin arbiter sharing one ADC between N clients: rdy synchroniser, service FSM
// and a conversion timeout counter.
module adc_arbiter
    import adc_pkg::*;
#(
    parameter int unsigned N_CLIENTS      = N_CLIENTS_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_CLIENTS-1:0] cli_req,
    output logic [N_CLIENTS-1:0] cli_rdy,
    output logic [DATA_W-1:0]    cli_dat,
    output logic [N_CLIENTS-1:0] cli_err,
    output logic [N_CLIENTS-1:0] grant,
    output logic                 adc_req,
    input  logic                 adc_rdy,
    input  logic [DATA_W-1:0]    adc_dat
);

    localparam int unsigned IdxW        = $clog2(N_CLIENTS);
    localparam logic [7:0]  TimeoutLoad = 8'(TIMEOUT_CYCLES);

    state_e                 state_q, state_d;
    logic                   rdy_meta_q, rdy_s;
    logic [1:0]             warm_q;
    logic [7:0]             cnt_q, cnt_d;
    logic [N_CLIENTS-1:0]   grant_q, grant_d, winner;
    logic [IdxW-1:0]        last_q, last_d, grant_idx;
    logic                   adc_req_q, adc_req_d;
    logic [DATA_W-1:0]      dat_q, dat_d;

    rr_picker #(
        .N    (N_CLIENTS),
        .IdxW (IdxW)
    ) u_rr_picker (
        .req    (cli_req),
        .last   (last_q),
        .winner (winner)
    );

    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < N_CLIENTS; i++) begin
            if (grant_q[i]) grant_idx = IdxW'(i);
        end
    end

    // Sync flops reset to 0 while adc_rdy may still be high from an aborted
    // conversion; warm_q holds off arbitration until rdy_s reflects the real input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_meta_q <= 1'b0;
            rdy_s      <= 1'b0;
            warm_q     <= '0;
        end else begin
            rdy_meta_q <= adc_rdy;
            rdy_s      <= rdy_meta_q;
            warm_q     <= {warm_q[0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            grant_q   <= '0;
            last_q    <= IdxW'(N_CLIENTS - 1);
            adc_req_q <= 1'b0;
            dat_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            adc_req_q <= adc_req_d;
            dat_q     <= dat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        last_d    = last_q;
        adc_req_d = adc_req_q;
        dat_d     = dat_q;
        cli_rdy   = '0;
        cli_err   = '0;
        unique case (state_q)
            StIdle: begin
                if (|cli_req && warm_q[1] && !rdy_s) begin
                    grant_d   = winner;
                    adc_req_d = 1'b1;
                    cnt_d     = TimeoutLoad;
                    state_d   = StReq;
                end
            end
            StReq: begin
                if (rdy_s) begin
                    dat_d     = adc_dat;
                    adc_req_d = 1'b0;
                    state_d   = StDone;
                end else if (cnt_q == 8'd0) begin
                    adc_req_d = 1'b0;
                    state_d   = StErr;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StDone: begin
                // A client that withdrew its request loses the result silently.
                cli_rdy = grant_q & cli_req;
                last_d  = grant_idx;
                state_d = StRelease;
            end
            StErr: begin
                cli_err = grant_q;
                last_d  = grant_idx;
                state_d = StRelease;
            end
            StRelease: begin
                if (!rdy_s) begin
                    grant_d = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign grant   = grant_q;
    assign adc_req = adc_req_q;
    assign cli_dat = dat_q;

endmodule

// File: doc/adc_arbiter.md
ADC_ARBITER -- requirements
Module: adc_arbiter

Interface
REQ-001 SHALL have parameter N_CLIENTS, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, clocks allowed for adc_rdy to rise after adc_req rises.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cli_req  input  N_CLIENTS  level request per client; one conversion per service.
REQ-006 SHALL have port cli_rdy  output  N_CLIENTS  one-cycle pulse to the served client; cli_dat valid in that cycle.
REQ-007 SHALL have port cli_dat  output  8  conversion result; shared by all clients.
REQ-008 SHALL have port cli_err  output  N_CLIENTS  one-cycle pulse to the granted client on timeout.
REQ-009 SHALL have port grant  output  N_CLIENTS  one-hot owner of the ADC; all-zero when idle.
REQ-010 SHALL have port adc_req  output  1  request to the ADC.
REQ-011 SHALL have port adc_rdy  input  1  ready from the ADC; asynchronous to clk.
REQ-012 SHALL have port adc_dat  input  8  ADC data; stable while adc_rdy is high.

Function
REQ-013 SHALL synchronise adc_rdy through two flip-flops; all FSM decisions use the synchronised rdy_s.
REQ-014 SHALL implement states IDLE, REQ, DONE, RELEASE, ERR.
REQ-015 IDLE: if any cli_req is high, SHALL pick a winner round-robin, set grant one-hot, set adc_req=1, and load the timeout counter, all in the same edge -> REQ.
REQ-016 Round-robin: the highest priority SHALL be client (last_served+1) mod N_CLIENTS; last_served SHALL reset to N_CLIENTS-1, so client 0 wins first.
REQ-017 REQ: on rdy_s=1, SHALL capture adc_dat into cli_dat and drop adc_req -> DONE; counter reaches 0 first -> drop adc_req -> ERR.
REQ-018 DONE (1 cycle): SHALL pulse cli_rdy[grant] only if cli_req[grant] is still high; otherwise discard the result silently. SHALL update last_served -> RELEASE.
REQ-019 RELEASE: SHALL wait for rdy_s=0, then clear grant -> IDLE. There is no timeout in this state.
REQ-020 ERR (1 cycle): SHALL pulse cli_err[grant] and update last_served -> RELEASE.
REQ-021 Minimum service: rising edge of adc_req to cli_rdy pulse SHALL be ADC latency + 3 clocks (2 sync + 1 DONE).
REQ-022 A client that holds cli_req high after its cli_rdy SHALL be treated as a new request under round-robin; it SHALL NOT win back-to-back while another client is requesting.
REQ-023 cli_req changes while a client holds grant SHALL NOT alter grant until the next IDLE arbitration.
REQ-024 cli_dat SHALL hold its last captured value until the next capture.
REQ-025 Timeout counter SHALL be an 8-bit down-counter with saturating check at 0; TIMEOUT_CYCLES=0 SHALL mean immediate ERR after one REQ cycle.

Reset
REQ-026 While reset=0: state IDLE; adc_req=0; grant, cli_rdy, cli_err all 0; cli_dat=8'h00; sync flops 0; last_served=N_CLIENTS-1.
REQ-027 Reset asserted mid-conversion SHALL drop adc_req asynchronously; the first arbitration after release SHALL wait for rdy_s=0.

Structure
REQ-028 Package adc_pkg SHALL hold the state enum, N_CLIENTS and TIMEOUT_CYCLES defaults, and the data width (8).
REQ-029 Round-robin selection SHALL be a separate sub-module rr_picker: inputs req and last; output one-hot winner. It is combinational.
REQ-030 The FSM, synchroniser and counter SHALL live in adc_arbiter.

Verification
REQ-031 Client 0 only, ADC returns 8'hC9 -> grant=0001, then adc_req, then cli_rdy[0] pulse with cli_dat=C9, then grant=0.
REQ-032 All 4 cli_req held high for 8 conversions -> service order 0,1,2,3,0,1,2,3 with no repeats.
REQ-033 ADC stalled (adc_rdy never rises), TIMEOUT_CYCLES=16 -> cli_err[k] pulse 17±1 clocks after adc_req rises; no cli_rdy pulse; next client is granted.
REQ-034 Client 2 drops cli_req mid-conversion -> adc_req handshake completes, no cli_rdy[2] pulse, and client 3 is served next.
REQ-035 reset=0 asserted while in REQ -> adc_req=0 within the same time step, all outputs at reset values; after release, client 0 is served first.
